ex_mem_skid_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_payload_reg.sv | 18 +
 rtl/ex_mem_skid_stage.sv | 83 ++++++++
 tb/tb_ex_mem_skid_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared EX/MEM control-field layout, bubble value and payload type
package pipe_pkg;
  localparam int CTRL_W = 6;
  localparam int MEMREAD_BIT = 5;
  localparam int MEMWRITE_BIT = 4;
  localparam int MEMTOREG_LSB = 2;
  localparam int REGWRITE_BIT = 1;
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0] wreg;
    logic [31:0] pc8;
  } ex_mem_payload_t;
endpackage

// File: rtl/pipe_payload_reg.sv
// pipe_payload_reg: payload holding register with load, clear-to-bubble and async reset
module pipe_payload_reg import pipe_pkg::*; #(
  parameter int W = $bits(ex_mem_payload_t),
  parameter logic [W-1:0] RST_VAL = '0
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // clear returns the entry to its bubble value; load captures new payload
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= RST_VAL;
    else if (clear) q <= RST_VAL;
    else if (load) q <= d;
endmodule

// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX->MEM boundary with two-entry skid buffer; EX_MEM_PERF_EN adds stall/flush counters
module ex_mem_skid_stage import pipe_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = pipe_pkg::BUBBLE_CTRL
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [REG_AW-1:0] in_wreg,
  input  logic [DATA_W-1:0] in_pc8,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [REG_AW-1:0] out_wreg,
  output logic [DATA_W-1:0] out_pc8
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);
  localparam int PW = CTRL_W + 3 * DATA_W + REG_AW;
  localparam logic [PW-1:0] RST_PL = {BUBBLE_CTRL, {(PW - CTRL_W){1'b0}}};
  logic mainValid, skidValid, accept, consume;
  logic mainLoad, mainClear, skidLoad, skidClear;
  logic [CTRL_W-1:0] inCtrl;
  logic [PW-1:0] inPayload, mainD, mainQ, skidQ;
  assign in_ready = !skidValid;
  assign out_valid = mainValid;
  assign {out_ctrl, out_alu, out_wdata, out_wreg, out_pc8} = mainQ;
  // handshake decode and next-entry steering; flush blocks every load
  always_comb begin
    accept = in_valid && in_ready;
    consume = mainValid && out_ready;
    inCtrl = (in_wreg == '0) ? in_ctrl & ~(CTRL_W'(1) << REGWRITE_BIT) : in_ctrl;
    inPayload = {inCtrl, in_alu, in_wdata, in_wreg, in_pc8};
    mainD = skidValid ? skidQ : inPayload;
    mainLoad = !flush && (skidValid ? consume : accept && (!mainValid || consume));
    mainClear = flush || (mainValid && !skidValid && consume && !accept);
    skidLoad = !flush && mainValid && !skidValid && accept && !consume;
    skidClear = flush || (skidValid && consume);
  end
  // occupancy tracking; in_ready follows skidValid so it is a plain register output
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else if (flush) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else begin
      mainValid <= skidValid || accept || (mainValid && !consume);
      skidValid <= skidValid ? !consume : skidLoad;
    end
  pipe_payload_reg #(.W(PW), .RST_VAL(RST_PL)) u_main (
    .clk(clk), .reset(reset), .load(mainLoad), .clear(mainClear), .d(mainD), .q(mainQ)
  );
  pipe_payload_reg #(.W(PW), .RST_VAL(RST_PL)) u_skid (
    .clk(clk), .reset(reset), .load(skidLoad), .clear(skidClear), .d(inPayload), .q(skidQ)
  );
`ifdef EX_MEM_PERF_EN
  logic [32:0] flushSum;
  assign flushSum = {1'b0, perf_flush_cnt} + 33'(mainValid) + 33'(skidValid);
  // saturating stall-cycle and killed-entry counters
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (mainValid && !out_ready && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush) perf_flush_cnt <= flushSum[32] ? '1 : flushSum[31:0];
    end
`endif
endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb_ex_mem_skid_stage: directed self-checking bench for ex_mem_skid_stage
module tb_ex_mem_skid_stage;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [5:0] in_ctrl = '0, out_ctrl;
  logic [31:0] in_alu = '0, in_wdata = '0, in_pc8 = '0, out_alu, out_wdata, out_pc8;
  logic [4:0] in_wreg = '0, out_wreg;
  int cmpCount = 0, badCount = 0;
`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
  always #5 clk = ~clk;
  ex_mem_skid_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_alu(in_alu), .in_wdata(in_wdata), .in_wreg(in_wreg), .in_pc8(in_pc8),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_alu(out_alu),
    .out_wdata(out_wdata), .out_wreg(out_wreg), .out_pc8(out_pc8)
`ifdef EX_MEM_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [5:0] c, input logic [31:0] a, input logic [4:0] r);
    in_valid = v;
    in_ctrl = c;
    in_alu = a;
    in_wdata = ~a;
    in_pc8 = a + 32'd8;
    in_wreg = r;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmpCount++; if (out_valid !== 1'b0) begin badCount++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    cmpCount++; if (in_ready !== 1'b1) begin badCount++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    cmpCount++; if (out_ctrl !== 6'd0) begin badCount++; $display("FAIL reset_out_ctrl got %h want 00", out_ctrl); end
    cmpCount++; if (out_alu !== 32'd0 || out_wreg !== 5'd0) begin badCount++; $display("FAIL reset_fields got alu=%h wreg=%0d want 0/0", out_alu, out_wreg); end
    reset = 1'b0;
    tick();
  endtask
  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 6'b000010, 32'h1000_0004, 5'd8);
    tick();
    drive(1'b0, 6'd0, 32'd0, 5'd0);
    cmpCount++; if (out_valid !== 1'b1) begin badCount++; $display("FAIL single_valid got %b want 1", out_valid); end
    cmpCount++; if (out_alu !== 32'h1000_0004) begin badCount++; $display("FAIL single_alu got %h want 10000004", out_alu); end
    cmpCount++; if (out_wreg !== 5'd8) begin badCount++; $display("FAIL single_wreg got %0d want 8", out_wreg); end
    cmpCount++; if (out_ctrl !== 6'b000010) begin badCount++; $display("FAIL single_ctrl got %b want 000010", out_ctrl); end
    cmpCount++; if (out_wdata !== 32'hEFFF_FFFB || out_pc8 !== 32'h1000_000C) begin badCount++; $display("FAIL single_data got wdata=%h pc8=%h want effffffb/1000000c", out_wdata, out_pc8); end
    tick();
    cmpCount++; if (out_valid !== 1'b0) begin badCount++; $display("FAIL single_drain_valid got %b want 0", out_valid); end
    cmpCount++; if (out_ctrl !== 6'd0) begin badCount++; $display("FAIL single_bubble_ctrl got %b want 000000", out_ctrl); end
  endtask
  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 6'b000010, 32'hA1, 5'd3);
    tick();
    cmpCount++; if (in_ready !== 1'b1) begin badCount++; $display("FAIL bp_one_ready got %b want 1", in_ready); end
    drive(1'b1, 6'b010000, 32'hB2, 5'd4);
    tick();
    drive(1'b0, 6'd0, 32'd0, 5'd0);
    cmpCount++; if (in_ready !== 1'b0) begin badCount++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    cmpCount++; if (out_alu !== 32'hA1 || out_valid !== 1'b1) begin badCount++; $display("FAIL bp_full_head got alu=%h v=%b want a1/1", out_alu, out_valid); end
    tick();
    cmpCount++; if (out_alu !== 32'hA1 || in_ready !== 1'b0) begin badCount++; $display("FAIL bp_hold got alu=%h rdy=%b want a1/0", out_alu, in_ready); end
    out_ready = 1'b1;
    tick();
    cmpCount++; if (out_alu !== 32'hB2 || out_wreg !== 5'd4 || out_ctrl !== 6'b010000) begin badCount++; $display("FAIL bp_second got alu=%h wreg=%0d ctrl=%b want b2/4/010000", out_alu, out_wreg, out_ctrl); end
    cmpCount++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin badCount++; $display("FAIL bp_second_flags got rdy=%b v=%b want 1/1", in_ready, out_valid); end
    tick();
    cmpCount++; if (out_valid !== 1'b0) begin badCount++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask
  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'b000010, 32'hC0 + 32'(i), 5'd9);
      tick();
      cmpCount++; if (out_valid !== 1'b1 || out_alu !== 32'hC0 + 32'(i)) begin badCount++; $display("FAIL b2b_%0d got v=%b alu=%h want 1/%h", i, out_valid, out_alu, 32'hC0 + 32'(i)); end
    end
    drive(1'b0, 6'd0, 32'd0, 5'd0);
    tick();
    cmpCount++; if (out_valid !== 1'b0) begin badCount++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask
  task automatic test_zero_reg();
    out_ready = 1'b1;
    drive(1'b1, 6'b100110, 32'h55, 5'd0);
    tick();
    drive(1'b0, 6'd0, 32'd0, 5'd0);
    cmpCount++; if (out_ctrl !== 6'b100100) begin badCount++; $display("FAIL zero_reg_ctrl got %b want 100100", out_ctrl); end
    tick();
  endtask
  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 6'b000010, 32'hA1, 5'd3);
    tick();
    drive(1'b1, 6'b000010, 32'hB2, 5'd4);
    tick();
    drive(1'b1, 6'b010010, 32'hCC, 5'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cmpCount++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin badCount++; $display("FAIL flush_full got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    cmpCount++; if (out_ctrl !== 6'd0 || out_wreg !== 5'd0) begin badCount++; $display("FAIL flush_full_bubble got ctrl=%b wreg=%0d want 000000/0", out_ctrl, out_wreg); end
    drive(1'b0, 6'd0, 32'd0, 5'd0);
    out_ready = 1'b1;
    tick();
    cmpCount++; if (out_valid !== 1'b0) begin badCount++; $display("FAIL flush_no_c got %b want 0", out_valid); end
    out_ready = 1'b0;
    drive(1'b1, 6'b000010, 32'hD0, 5'd5);
    tick();
    drive(1'b1, 6'b000010, 32'hDD, 5'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 6'd0, 32'd0, 5'd0);
    tick();
    cmpCount++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin badCount++; $display("FAIL flush_one_drop got v=%b rdy=%b want 0/1", out_valid, in_ready); end
  endtask
  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 6'b000010, 32'hE1, 5'd2);
    tick();
    drive(1'b0, 6'd0, 32'd0, 5'd0);
    cmpCount++; if (out_valid !== 1'b1) begin badCount++; $display("FAIL areset_pre got %b want 1", out_valid); end
    #2 reset = 1'b1;
    #1;
    cmpCount++; if (out_valid !== 1'b0 || out_ctrl !== 6'd0 || in_ready !== 1'b1) begin badCount++; $display("FAIL areset_now got v=%b ctrl=%b rdy=%b want 0/000000/1", out_valid, out_ctrl, in_ready); end
    #1 reset = 1'b0;
    tick();
  endtask
`ifdef EX_MEM_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    out_ready = 1'b0;
    drive(1'b1, 6'b000010, 32'hF1, 5'd1);
    tick();
    drive(1'b1, 6'b000010, 32'hF2, 5'd2);
    tick();
    drive(1'b0, 6'd0, 32'd0, 5'd0);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cmpCount++; if (perf_stall_cnt !== 32'd5) begin badCount++; $display("FAIL perf_stall got %0d want 5", perf_stall_cnt); end
    cmpCount++; if (perf_flush_cnt !== 32'd2) begin badCount++; $display("FAIL perf_flush got %0d want 2", perf_flush_cnt); end
    tick();
    cmpCount++; if (perf_stall_cnt !== 32'd5) begin badCount++; $display("FAIL perf_stall_idle got %0d want 5", perf_stall_cnt); end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_zero_reg();
    test_flush();
    test_async_reset();
`ifdef EX_MEM_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, badCount);
    $finish;
  end
endmodule
